rca_pipe_addsub: RTL and testbench
==================================

Name: rca_pipe_addsub

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor for the arithmetic datapath.
- Generalises the fixed 5-bit HA/FA ripple adder to WIDTH bits, split into SEG-bit ripple segments with one register stage per segment.
- Adds subtract mode, carry/borrow-in, signed-overflow flag and a valid/ready handshake with backpressure.
- Feeds the Vedic multiplier partial-product accumulation and other accumulators.

Parameters:
- WIDTH, 16, operand and result width in bits; must be >= 2.
- SEG, 4, bits per ripple segment; must be >= 1 and <= WIDTH.
- STAGES, derived: ceil(WIDTH/SEG), the number of pipeline stages. The last segment holds the remaining WIDTH - (STAGES-1)*SEG bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- i1  input  WIDTH  operand A.
- i2  input  WIDTH  operand B.
- Cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- Sum  output  WIDTH  result.
- Cout  output  1  carry-out. In sub mode, 1 means no borrow.
- Ovf  output  1  two's-complement signed overflow.

Behaviour:
- Arithmetic:
  - add: {Cout,Sum} = i1 + i2 + Cin.
  - sub: {Cout,Sum} = i1 + ~i2 + ~Cin, i.e. i1 - i2 - Cin.
  - Ovf = carry into MSB XOR carry out of MSB.
  - All operations are modulo 2^WIDTH.
- Datapath:
  - Stage k (0..STAGES-1) ripple-adds segment k using the registered carry from stage k-1. Stage 0 uses the effective carry-in.
  - Upper operand segments are carried forward in skew registers.
  - Lower sum segments are carried forward in de-skew registers.
  - No combinational path longer than one SEG-bit ripple plus the mux.
  - The sub inversion of i2 and Cin is applied at the input, before stage 0.
- Latency: a beat accepted at edge t appears on Sum/Cout/Ovf with out_valid=1 after edge t+STAGES-1 (STAGES cycles), provided there is no stall.
- Handshake:
  - Global enable en = !out_valid | out_ready; in_ready = en.
  - A beat is accepted when in_valid & in_ready.
  - When en=1 every stage register advances. A stage valid bit loads from the previous stage, or from the in_valid&in_ready term for stage 0.
  - When en=0 all stage registers, including data, hold.
  - Bubbles are not collapsed. Throughput is 1 beat/cycle when out_ready is held at 1.
- Output stability: while out_valid=1 and out_ready=0, Sum, Cout and Ovf hold stable.
- Reset:
  - Asserting rst at any time, including mid-stream, asynchronously clears all stage valid bits. out_valid becomes 0 immediately; Sum, Cout and Ovf become 0.
  - In-flight beats are discarded, not flushed.
  - in_ready is 1 during and after reset, because out_valid=0.
- Boundaries:
  - Simultaneous output pop and input push in the same cycle is legal, with no loss.
  - When SEG >= WIDTH, STAGES=1 and latency is 1 cycle.
  - Wrap-around, e.g. max+1, gives Sum=0 and Cout=1.
  - Input values are ignored when in_valid=0 or in_ready=0.
  - Each beat's sub and Cin travel with that beat, so mixed add/sub streams are correct.

Test Plan (WIDTH=16, SEG=4, latency 4):
- Reset then add: i1=0x1234, i2=0x0FCD, Cin=0, sub=0 -> 4 cycles later Sum=0x2201, Cout=0, Ovf=0.
- Wrap and overflow: i1=0xFFFF, i2=0x0001 -> Sum=0x0000, Cout=1, Ovf=0. Then i1=0x7FFF, i2=0x0001 -> Sum=0x8000, Cout=0, Ovf=1.
- Subtract with borrow: i1=0x0005, i2=0x0007, sub=1, Cin=0 -> Sum=0xFFFE, Cout=0. Then i1=0x8000, i2=0x0001, sub=1 -> Sum=0x7FFF, Ovf=1. Then i1=0x0010, i2=0x0003, sub=1, Cin=1 -> Sum=0x000C, Cout=1.
- Back-to-back stream with backpressure: 20 random beats with in_valid=1 and out_ready toggling randomly -> results in order, exactly matching the reference model; no drops or duplicates; Sum stable while out_valid&!out_ready.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid falls at once (asynchronously), none of the 3 results appear after reset release, and the next accepted beat returns correctly after 4 cycles.
- Parameter sweep: (WIDTH=5, SEG=5) and (WIDTH=13, SEG=4) -> latency 1 and 4 respectively; exhaustive check for WIDTH=5 against i1+i2+Cin for both modes.

Source files
------------

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor.
// The operand is split into SEG-bit segments; each segment ripples in its own
// stage using the carry registered by the stage before it. Operand bits not yet
// consumed travel forward in skew registers, finished sum bits in de-skew
// registers, so the longest combinational path is one SEG-bit ripple.
// A single global enable stalls every stage together when the output is held.
module rca_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);
    localparam int STAGES = (WIDTH + SEG - 1) / SEG;

    // The pipeline only advances when the output slot is empty or being drained.
    logic en;
    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_st
            localparam int LO = k * SEG;                              // first bit of this segment
            localparam int W  = (WIDTH - LO < SEG) ? WIDTH - LO : SEG; // segment width
            localparam int HI = LO + W;                               // sum bits done after this stage
            localparam int RW = WIDTH - HI;                           // operand bits still pending

            logic [WIDTH-LO-1:0] xa, xb;   // operand bits from this segment upward
            logic                xc, xv;   // incoming carry and beat valid
            logic [W-1:0]        ss;
            logic [W:0]          cc;
            logic [HI-1:0]       sd;
            logic [HI-1:0]       s_q;
            logic                c_q, v_q;

            if (k == 0) begin : g_head
                // Subtraction is a + ~b + ~borrow; inversion happens before stage 0.
                assign xa = i1;
                assign xb = i2 ^ {WIDTH{sub}};
                assign xc = Cin ^ sub;
                assign xv = in_valid & in_ready;
                assign sd = ss;
            end else begin : g_body
                assign xa = g_st[k-1].g_fwd.a_q;
                assign xb = g_st[k-1].g_fwd.b_q;
                assign xc = g_st[k-1].c_q;
                assign xv = g_st[k-1].v_q;
                assign sd = {ss, g_st[k-1].s_q};
            end

            // Ripple this segment bit by bit from the incoming carry.
            always_comb begin
                cc    = '0;
                ss    = '0;
                cc[0] = xc;
                for (int i = 0; i < W; i++) begin
                    ss[i]   = xa[i] ^ xb[i] ^ cc[i];
                    cc[i+1] = (xa[i] & xb[i]) | (cc[i] & (xa[i] ^ xb[i]));
                end
            end

            // Stage register: valid, carry out of this segment, sum bits so far.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    s_q <= '0;
                end else if (en) begin
                    v_q <= xv;
                    c_q <= cc[W];
                    s_q <= sd;
                end
            end

            if (RW > 0) begin : g_fwd
                logic [RW-1:0] a_q, b_q;
                // Skew registers carry the not-yet-added operand bits forward.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (en) begin
                        a_q <= xa[WIDTH-LO-1:W];
                        b_q <= xb[WIDTH-LO-1:W];
                    end
                end
            end else begin : g_last
                logic o_q;
                // Signed overflow: carry into the MSB differs from carry out of it.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)
                        o_q <= 1'b0;
                    else if (en)
                        o_q <= cc[W] ^ cc[W-1];
                end
            end
        end
    endgenerate

    assign out_valid = g_st[STAGES-1].v_q;
    assign Sum       = g_st[STAGES-1].s_q;
    assign Cout      = g_st[STAGES-1].c_q;
    assign Ovf       = g_st[STAGES-1].g_last.o_q;
endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Directed bench for rca_pipe_addsub: a 16/4 instance for the main checks,
// plus 5/5 and 13/4 instances for the latency-1 and uneven-segment cases.
module tb_rca_pipe_addsub;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 16-bit, 4 stages
    logic        in_valid, in_ready, Cin, sub, out_valid, out_ready, Cout, Ovf;
    logic [15:0] i1, i2, Sum;
    // 5-bit, 1 stage
    logic        iv5, ir5, c5, s5, ov5, or5, co5, of5;
    logic [4:0]  a5, b5, sum5;
    // 13-bit, 4 stages (last segment 1 bit)
    logic        iv13, ir13, c13, s13, ov13, or13, co13, of13;
    logic [12:0] a13, b13, sum13;

    int n_cmp = 0;
    int n_err = 0;

    rca_pipe_addsub #(.WIDTH(16), .SEG(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .i1(i1), .i2(i2), .Cin(Cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf));

    rca_pipe_addsub #(.WIDTH(5), .SEG(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5),
        .i1(a5), .i2(b5), .Cin(c5), .sub(s5),
        .out_valid(ov5), .out_ready(or5),
        .Sum(sum5), .Cout(co5), .Ovf(of5));

    rca_pipe_addsub #(.WIDTH(13), .SEG(4)) dut13 (
        .clk(clk), .rst(rst), .in_valid(iv13), .in_ready(ir13),
        .i1(a13), .i2(b13), .Cin(c13), .sub(s13),
        .out_valid(ov13), .out_ready(or13),
        .Sum(sum13), .Cout(co13), .Ovf(of13));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {ovf, cout, sum} for a w-bit add or subtract.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic s);
        logic [31:0] m, bb, sm;
        logic [63:0] tot;
        logic        co, ov;
        m   = (32'd1 << w) - 32'd1;
        bb  = s ? (~b & m) : (b & m);
        tot = 64'(a & m) + 64'(bb) + 64'(c ^ s);
        sm  = tot[31:0] & m;
        co  = tot[w];
        ov  = (a[w-1] == bb[w-1]) && (sm[w-1] != a[w-1]);
        return {ov, co, sm};
    endfunction

    // One beat through the 16-bit pipe with out_ready held high; checks latency and result.
    task automatic send16(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s,
                          input logic [15:0] es, input logic ec, input logic eo);
        i1 = a; i2 = b; Cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        // scramble idle inputs; they must not affect the beat in flight
        in_valid = 1'b0; i1 = 16'hA5A5; i2 = 16'h5A5A; Cin = ~c; sub = ~s;
        for (int j = 0; j < 3; j++) begin
            chk({tag, "_early"}, 64'(out_valid), 64'(0));
            @(posedge clk); #1;
        end
        chk({tag, "_vld"},  64'(out_valid), 64'(1));
        chk({tag, "_sum"},  64'(Sum),       64'(es));
        chk({tag, "_cout"}, 64'(Cout),      64'(ec));
        chk({tag, "_ovf"},  64'(Ovf),       64'(eo));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [33:0] r;
        logic [17:0] q[$];
        logic [17:0] held, fr;
        logic        stall;
        int          sent, rcvd, cyc;

        rst = 1'b1;
        in_valid = 0; i1 = 0; i2 = 0; Cin = 0; sub = 0; out_ready = 1;
        iv5 = 0; a5 = 0; b5 = 0; c5 = 0; s5 = 0; or5 = 1;
        iv13 = 0; a13 = 0; b13 = 0; c13 = 0; s13 = 0; or13 = 1;
        #1;
        chk("rst_vld",   64'(out_valid), 64'(0));
        chk("rst_sum",   64'(Sum),       64'(0));
        chk("rst_cout",  64'(Cout),      64'(0));
        chk("rst_ovf",   64'(Ovf),       64'(0));
        chk("rst_ready", 64'(in_ready),  64'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // directed add / wrap / overflow / subtract
        send16("add",     16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
        send16("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send16("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send16("sub_brw", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send16("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send16("sub_bin", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);

        // 20-beat stream, random operands/modes, random backpressure
        sent = 0; rcvd = 0; cyc = 0; stall = 1'b0; held = '0;
        while ((sent < 20 || q.size() > 0) && cyc < 400) begin
            if (stall) begin
                chk("hold_vld", 64'(out_valid), 64'(1));
                chk("hold_res", 64'({Ovf, Cout, Sum}), 64'(held));
            end
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 20) begin
                in_valid = 1'b1;
                i1  = 16'($urandom);
                i2  = 16'($urandom);
                Cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            stall = out_valid && !out_ready;
            held  = {Ovf, Cout, Sum};
            if (out_valid && out_ready) begin
                rcvd++;
                if (q.size() > 0) begin
                    fr = q.pop_front();
                    chk("stream", 64'({Ovf, Cout, Sum}), 64'(fr));
                end
            end
            if (in_valid && in_ready) begin
                r = model(16, 32'(i1), 32'(i2), Cin, sub);
                q.push_back({r[33], r[32], r[15:0]});
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_sent", 64'(sent), 64'(20));
        chk("stream_rcvd", 64'(rcvd), 64'(20));

        // reset with beats in flight
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; i1 = 16'(k + 1); i2 = 16'h0100; Cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre_rst_vld", 64'(out_valid), 64'(1));
        chk("pre_rst_sum", 64'(Sum),       64'(16'h0101));
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_vld",   64'(out_valid), 64'(0));
        chk("arst_sum",   64'(Sum),       64'(0));
        chk("arst_ready", 64'(in_ready),  64'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("post_rst_vld", 64'(out_valid), 64'(0));
            @(posedge clk); #1;
        end
        send16("after_rst", 16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);

        // 13-bit, SEG=4: latency 4 with a 1-bit last segment
        a13 = 13'h1FFF; b13 = 13'h0001; c13 = 1'b0; s13 = 1'b0; iv13 = 1'b1;
        @(posedge clk); #1;
        a13 = 13'h0FFF; b13 = 13'h0001; c13 = 1'b0; s13 = 1'b0;
        @(posedge clk); #1;
        a13 = 13'h0000; b13 = 13'h0001; c13 = 1'b0; s13 = 1'b1;
        @(posedge clk); #1;
        iv13 = 1'b0;
        chk("w13_early", 64'(ov13), 64'(0));
        @(posedge clk); #1;
        chk("w13_wrap", 64'({ov13, of13, co13, sum13}), 64'({1'b1, 1'b0, 1'b1, 13'h0000}));
        @(posedge clk); #1;
        chk("w13_ovf",  64'({ov13, of13, co13, sum13}), 64'({1'b1, 1'b1, 1'b0, 13'h1000}));
        @(posedge clk); #1;
        chk("w13_sub",  64'({ov13, of13, co13, sum13}), 64'({1'b1, 1'b0, 1'b0, 13'h1FFF}));
        @(posedge clk); #1;
        chk("w13_drain", 64'(ov13), 64'(0));

        // 5-bit, SEG=5: single stage, exhaustive both modes and carry-ins
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int a = 0; a < 32; a++)
                    for (int b = 0; b < 32; b++) begin
                        a5 = 5'(a); b5 = 5'(b); c5 = 1'(c); s5 = 1'(s); iv5 = 1'b1;
                        @(posedge clk); #1;
                        r = model(5, 32'(a), 32'(b), 1'(c), 1'(s));
                        chk("w5", 64'({ov5, of5, co5, sum5}), 64'({1'b1, r[33], r[32], r[4:0]}));
                    end
        iv5 = 1'b0;
        @(posedge clk); #1;
        chk("w5_drain", 64'(ov5), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
